// File: rtl/shift_left_capture_pkg.sv
// Shared definitions for the SPM serial-product capture register.
package shift_left_capture_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SKIP  = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam int unsigned PRODUCT_W    = 64;
   localparam int unsigned DEFAULT_LEAD = 1;
   localparam int unsigned LEAD_CNT_W   = 2;

   // First capture state after start: skip the transmitter's load cycle unless LEAD is zero.
   function automatic state_t entry_state(input int unsigned lead);
      return (lead == 0) ? SHIFT : SKIP;
   endfunction

endpackage

// File: rtl/shift_left_capture.sv
// Serial-in, parallel-out capture of an LSB-first word with a valid/ready output.
module shift_left_capture
   import shift_left_capture_pkg::*;
#(
   parameter int unsigned WIDTH = PRODUCT_W,
   parameter int unsigned LEAD  = DEFAULT_LEAD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   input  logic             ready,
   output logic             busy,
   output logic             overrun
);

   localparam int unsigned CNT_W     = $clog2(WIDTH);
   localparam int unsigned LEAD_LAST = (LEAD == 0) ? 0 : LEAD - 1;
   localparam logic [CNT_W-1:0]      BIT_END  = CNT_W'(WIDTH - 1);
   localparam logic [LEAD_CNT_W-1:0] LEAD_END = LEAD_CNT_W'(LEAD_LAST);

   state_t                state, state_n;
   logic [WIDTH-1:0]      sr;
   logic [WIDTH-1:0]      sr_shifted;
   logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
   logic [LEAD_CNT_W-1:0] lead_cnt, lead_cnt_n;
   logic                  shift_en;
   logic                  capture_en;
   logic                  overrun_n;

   assign sr_shifted = {in, sr[WIDTH-1:1]};

   // State register plus registered status outputs decoded from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         valid   <= 1'b0;
         busy    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_n;
         valid   <= (state_n == HOLD);
         busy    <= (state_n == SKIP) || (state_n == SHIFT);
         overrun <= overrun_n;
      end
   end

   // Next-state, counter and datapath-enable decode.
   always_comb begin
      state_n    = state;
      bit_cnt_n  = bit_cnt;
      lead_cnt_n = lead_cnt;
      shift_en   = 1'b0;
      capture_en = 1'b0;
      overrun_n  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_n    = entry_state(LEAD);
               bit_cnt_n  = '0;
               lead_cnt_n = '0;
            end
         end
         SKIP: begin
            if (start) begin
               state_n    = entry_state(LEAD);
               bit_cnt_n  = '0;
               lead_cnt_n = '0;
            end else if (lead_cnt == LEAD_END) begin
               state_n   = SHIFT;
               bit_cnt_n = '0;
            end else begin
               lead_cnt_n = lead_cnt + 1'b1;
            end
         end
         SHIFT: begin
            // A start here aborts; the old bits are overwritten by the new word.
            if (start) begin
               state_n    = entry_state(LEAD);
               bit_cnt_n  = '0;
               lead_cnt_n = '0;
            end else begin
               shift_en = 1'b1;
               if (bit_cnt == BIT_END) begin
                  capture_en = 1'b1;
                  state_n    = HOLD;
                  bit_cnt_n  = '0;
               end else begin
                  bit_cnt_n = bit_cnt + 1'b1;
               end
            end
         end
         HOLD: begin
            if (ready) begin
               if (start) begin
                  state_n    = entry_state(LEAD);
                  bit_cnt_n  = '0;
                  lead_cnt_n = '0;
               end else begin
                  state_n = IDLE;
               end
            end else if (start) begin
               overrun_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Shift register, counters and the output word (written only on completion).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr       <= '0;
         data     <= '0;
         bit_cnt  <= '0;
         lead_cnt <= '0;
      end else begin
         bit_cnt  <= bit_cnt_n;
         lead_cnt <= lead_cnt_n;
         if (shift_en) begin
            sr <= sr_shifted;
         end
         if (capture_en) begin
            data <= sr_shifted;
         end
      end
   end

endmodule

// File: doc/shift_left_capture.md
Name: shift_left_capture

Overview:
- Serial-in, parallel-out capture register: the receiving end of the SPM serial product stream.
- Collects WIDTH bits, LSB first, from a parallel-load shift-right transmitter and presents them as one parallel word.
- Output side uses a valid/ready handshake.
- Sits at the multiplier output boundary and shares the transmitter's `ld` pulse as its `start`.

Parameters:
- WIDTH, 64, bits per captured word (≥2).
- LEAD, 1, cycles discarded after `start` before the first data bit is sampled (0..3). Default 1 matches the transmitter's zero output during its load cycle.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  begin a new capture; driven by the same pulse as the transmitter's load
- in  input  1  serial data bit, LSB first
- data  output  WIDTH  captured word
- valid  output  1  data holds a complete word
- ready  input  1  consumer accepts data when valid && ready
- busy  output  1  capture in progress (SKIP or SHIFT state)
- overrun  output  1  one-cycle pulse: start was dropped because a word was still held

Behaviour:
- Reset (rst=0, async): state=IDLE, data=0, valid=0, busy=0, overrun=0, internal shift register=0, counters=0. Reset mid-capture or mid-hold discards everything; no partial word is ever presented.
- States: IDLE, SKIP, SHIFT, HOLD. Outputs: busy = (SKIP|SHIFT); valid = HOLD.
- IDLE:
  - start=1: lead counter=0, go to SKIP, or straight to SHIFT if LEAD=0.
  - Otherwise stay; `in` is ignored.
- SKIP:
  - Discard `in` for LEAD edges, then go to SHIFT with bit counter=0.
- SHIFT:
  - Each edge: sr <= {in, sr[WIDTH-1:1]}; bit counter increments.
  - On the edge with counter=WIDTH-1: data <= {in, sr[WIDTH-1:1]}, valid rises, go to HOLD.
  - The first sampled bit lands in data[0].
- Latency: start sampled at edge E0 → valid high after edge E(LEAD+WIDTH). Default: E65.
- HOLD:
  - data is stable while valid=1.
  - valid && ready: accept. Go to IDLE, or to SKIP/SHIFT if start=1 in the same cycle (back-to-back capture, no bubble).
  - start=1 && ready=0: start is ignored, overrun pulses for one cycle, HOLD is kept.
- start in SKIP or SHIFT: abort the current capture and restart (counters=0, sr unchanged but fully overwritten). Matches transmitter reload semantics.
- Counter widths: clog2(WIDTH) for the bit counter, 2 bits for the lead counter. No wrap occurs; the terminal count is always decoded explicitly.
- data is only written on completion; it retains the last word through IDLE/SKIP/SHIFT.

Decomposition:
- Shared SPM header (spm_defs.vh) holds:
  - state encodings (IDLE=2'd0, SKIP=2'd1, SHIFT=2'd2, HOLD=2'd3)
  - default operand/product widths (32/64)
  - default LEAD=1
- No sub-module: counters, shift register and FSM are one always-block set of about 150 lines.

Test Plan:
- Reset: rst=0 asynchronously mid-SHIFT → data=0, valid=0, busy=0 immediately. After release with no start, valid stays 0 for 100 cycles.
- Loopback: WIDTH=64 instance, LEAD=1, driven by the transmitter with x=64'hDEAD_BEEF_0123_4567 and shared start/ld.
  - Required: valid rises exactly 65 edges after the start edge.
  - Required: data=64'hDEAD_BEEF_0123_4567 and busy falls on the same edge.
- Directed bits: WIDTH=8, LEAD=0, start then in=1,0,1,0,0,1,0,1 on consecutive edges → data=8'hA5, valid after the 8th edge. Holding ready=0 keeps data=8'hA5 for 20 cycles.
- Back-to-back:
  - WIDTH=8 in HOLD with ready=1 and start=1 in the same cycle → valid drops, no overrun, busy=1 next cycle.
  - Second word 8'h3C is then captured correctly.
- Overrun: WIDTH=8, HOLD with ready=0, start=1 → overrun=1 for exactly one cycle, state stays HOLD, data unchanged.
- Restart: WIDTH=8, start again after 5 bits of 8'hFF → the capture restarts. After 8 further bits of 8'h0F, data=8'h0F with no residue from the aborted word.
